// File: rtl/wallace_mac_acc_if.sv
// wallace_mac_acc_if: operand stream, multiplier hook-up and result stream
// of the Wallace-tree multiply-accumulate wrapper. The slave modport is the
// MAC block itself; the master modport is its environment (producer,
// external multiplier and result consumer).
interface wallace_mac_acc_if #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 16
);
    // operand stream
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_a;
    logic [31:0]       in_b;
    logic              in_last;
    logic              acc_clr;
    // external combinational multiplier
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic [63:0]       mul_p;
    // result stream
    logic              res_valid;
    logic              res_ready;
    logic [ACC_W-1:0]  res_data;
    logic [CNT_W-1:0]  res_count;
    logic              res_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_last, acc_clr, mul_p, res_ready,
        output in_ready, mul_a, mul_b, res_valid, res_data, res_count, res_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_last, acc_clr, mul_p, res_ready,
        input  in_ready, mul_a, mul_b, res_valid, res_data, res_count, res_ovf
    );
endinterface

// File: rtl/wallace_mac_acc.sv
// wallace_mac_acc: registers unsigned operand pairs onto an external 32x32
// Wallace-tree multiplier, captures the 64-bit product one cycle later and
// accumulates it into an ACC_W-bit sum. The beat flagged last closes the sum,
// which is then offered with its beat count and a sticky overflow flag.
// Optional feature macro: WALLACE_MAC_SAT_EN -- when defined the accumulator
// saturates to all-ones on overflow instead of wrapping.
module wallace_mac_acc #(
    parameter int ACC_W = 72,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    wallace_mac_acc_if.slave   bus
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_FLUSH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

    logic [1:0]       state_q,     state_d;
    logic             in_ready_q,  in_ready_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      mul_a_q,     mul_a_d;
    logic [31:0]      mul_b_q,     mul_b_d;
    logic             v1_q,        v1_d;
    logic             l1_q,        l1_d;
    logic [63:0]      p2_q,        p2_d;
    logic             v2_q,        v2_d;
    logic             l2_q,        l2_d;
    logic [ACC_W-1:0] acc_q,       acc_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic             ovf_q,       ovf_d;

    logic             accept_s;
    logic             clr_s;
    logic             drain_s;
    logic [ACC_W:0]   sum_s;
    logic             carry_s;

    // Handshake qualifiers and the widened accumulate sum with its carry.
    always_comb begin
        accept_s = bus.in_valid && in_ready_q;
        // abort only has effect while a sum is still being collected
        clr_s    = bus.acc_clr && (state_q == ST_RUN);
        drain_s  = (state_q == ST_HOLD) && bus.res_ready;
        sum_s    = {1'b0, acc_q} + {{(ACC_W - 63){1'b0}}, p2_q};
        carry_s  = sum_s[ACC_W];
    end

    // Operand and product pipeline stages; abort kills beats in flight but
    // keeps a beat accepted in the same cycle.
    always_comb begin
        mul_a_d = mul_a_q;
        mul_b_d = mul_b_q;
        if (accept_s) begin
            mul_a_d = bus.in_a;
            mul_b_d = bus.in_b;
            v1_d    = 1'b1;
            l1_d    = bus.in_last;
        end else begin
            v1_d    = 1'b0;
            l1_d    = 1'b0;
        end

        if (v1_q) begin
            p2_d = bus.mul_p;
            l2_d = l1_q;
        end else begin
            p2_d = p2_q;
            l2_d = 1'b0;
        end
        v2_d = v1_q && !clr_s;
    end

    // Accumulator, saturating beat counter and sticky overflow.
    always_comb begin
        acc_d = acc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_s || drain_s) begin
            acc_d = {ACC_W{1'b0}};
            cnt_d = {CNT_W{1'b0}};
            ovf_d = 1'b0;
        end else if (v2_q) begin
`ifdef WALLACE_MAC_SAT_EN
            // once overflowed, the sum is pinned at all-ones until drained
            if (carry_s || ovf_q) begin
                acc_d = {ACC_W{1'b1}};
            end else begin
                acc_d = sum_s[ACC_W-1:0];
            end
`else
            acc_d = sum_s[ACC_W-1:0];
`endif
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + {{(CNT_W - 1){1'b0}}, 1'b1};
            end else begin
                cnt_d = cnt_q;
            end
            ovf_d = ovf_q | carry_s;
        end else begin
            acc_d = acc_q;
        end
    end

    // Sum-level control: collect beats, drain the last one, offer the result.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (accept_s && bus.in_last) begin
                    state_d = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FLUSH: begin
                if (v2_q && l2_q) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            ST_HOLD: begin
                if (bus.res_ready) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // handshake flags are registered decodes of the next state
        in_ready_d  = (state_d == ST_RUN);
        res_valid_d = (state_d == ST_HOLD);
    end

    // State registers with asynchronous reset to an idle, ready block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            in_ready_q  <= 1'b1;
            res_valid_q <= 1'b0;
            mul_a_q     <= 32'd0;
            mul_b_q     <= 32'd0;
            v1_q        <= 1'b0;
            l1_q        <= 1'b0;
            p2_q        <= 64'd0;
            v2_q        <= 1'b0;
            l2_q        <= 1'b0;
            acc_q       <= {ACC_W{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            res_valid_q <= res_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            v1_q        <= v1_d;
            l1_q        <= l1_d;
            p2_q        <= p2_d;
            v2_q        <= v2_d;
            l2_q        <= l2_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.mul_a     = mul_a_q;
    assign bus.mul_b     = mul_b_q;
    assign bus.res_data  = acc_q;
    assign bus.res_count = cnt_q;
    assign bus.res_ovf   = ovf_q;

endmodule

// File: tb/tb_wallace_mac_acc.sv
// tb_wallace_mac_acc: directed bench for wallace_mac_acc. A 72-bit instance
// covers the main function; a 64-bit instance covers accumulator overflow.
// The external multiplier is modelled behaviourally on each interface.
module tb_wallace_mac_acc;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] r;

    wallace_mac_acc_if #(.ACC_W(72), .CNT_W(16)) bus ();
    wallace_mac_acc_if #(.ACC_W(64), .CNT_W(16)) bus64 ();

    assign bus.mul_p   = {32'd0, bus.mul_a} * {32'd0, bus.mul_b};
    assign bus64.mul_p = {32'd0, bus64.mul_a} * {32'd0, bus64.mul_b};

    wallace_mac_acc #(.ACC_W(72), .CNT_W(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    wallace_mac_acc #(.ACC_W(64), .CNT_W(16)) dut64 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus64)
    );

    // free-running clock, 10 time units per period
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // one active edge, returning at the following falling edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic idle();
        bus.in_valid    = 1'b0;
        bus.in_a        = 32'd0;
        bus.in_b        = 32'd0;
        bus.in_last     = 1'b0;
        bus.acc_clr     = 1'b0;
        bus.res_ready   = 1'b0;
        bus64.in_valid  = 1'b0;
        bus64.in_a      = 32'd0;
        bus64.in_b      = 32'd0;
        bus64.in_last   = 1'b0;
        bus64.acc_clr   = 1'b0;
        bus64.res_ready = 1'b0;
    endtask

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic last);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_last  = last;
    endtask

    task automatic beat64(input logic [31:0] a, input logic [31:0] b, input logic last);
        bus64.in_valid = 1'b1;
        bus64.in_a     = a;
        bus64.in_b     = b;
        bus64.in_last  = last;
    endtask

    initial begin
        logic [95:0] exp_ovf_data;
        clk    = 1'b0;
        rst_n  = 1'b0;
        checks = 0;
        errors = 0;
        idle();

        // ---------------- reset with random inputs ----------------
        repeat (4) begin
            @(negedge clk);
            r = $urandom();
            bus.in_valid  = r[0];
            bus.in_last   = r[1];
            bus.acc_clr   = r[2];
            bus.res_ready = r[3];
            bus.in_a      = $urandom();
            bus.in_b      = $urandom();
        end
        check("rst_in_ready",  bus.in_ready,  96'd1);
        check("rst_res_valid", bus.res_valid, 96'd0);
        check("rst_mul_a",     bus.mul_a,     96'd0);
        check("rst_mul_b",     bus.mul_b,     96'd0);
        check("rst_res_data",  bus.res_data,  96'd0);
        check("rst_res_count", bus.res_count, 96'd0);
        check("rst_res_ovf",   bus.res_ovf,   96'd0);
        idle();
        rst_n = 1'b1;
        cyc(3);
        check("rel_in_ready",  bus.in_ready,  96'd1);
        check("rel_res_valid", bus.res_valid, 96'd0);
        check("rel_res_data",  bus.res_data,  96'd0);

        // ---------------- single beat 3*5 ----------------
        beat(32'd3, 32'd5, 1'b1);
        cyc(1);                                  // edge 0
        check("sb_in_ready_low", bus.in_ready, 96'd0);
        check("sb_mul_a",        bus.mul_a,    96'd3);
        check("sb_mul_b",        bus.mul_b,    96'd5);
        idle();
        bus.acc_clr = 1'b1;                      // must be ignored while flushing
        cyc(1);                                  // edge 1
        bus.acc_clr = 1'b0;
        check("sb_valid_early", bus.res_valid, 96'd0);
        cyc(1);                                  // edge 2
        check("sb_res_valid", bus.res_valid, 96'd1);
        check("sb_res_data",  bus.res_data,  96'd15);
        check("sb_res_count", bus.res_count, 96'd1);
        check("sb_res_ovf",   bus.res_ovf,   96'd0);
        check("sb_ready_hold", bus.in_ready, 96'd0);
        cyc(2);
        check("sb_wait_valid", bus.res_valid, 96'd1);
        check("sb_wait_ready", bus.in_ready,  96'd0);
        bus.res_ready = 1'b1;
        cyc(1);
        bus.res_ready = 1'b0;
        check("sb_done_valid", bus.res_valid, 96'd0);
        check("sb_done_ready", bus.in_ready,  96'd1);

        // ---------------- stream of 4 max beats ----------------
        for (int i = 0; i < 4; i++) begin
            check("st_in_ready", bus.in_ready, 96'd1);
            beat(32'hFFFF_FFFF, 32'hFFFF_FFFF, (i == 3) ? 1'b1 : 1'b0);
            cyc(1);
        end
        idle();
        cyc(2);
        check("st_res_valid", bus.res_valid, 96'd1);
        check("st_res_data",  bus.res_data,  96'h3_FFFF_FFF8_0000_0004);
        check("st_res_count", bus.res_count, 96'd4);
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            check("st_hold_valid", bus.res_valid, 96'd1);
            check("st_hold_data",  bus.res_data,  96'h3_FFFF_FFF8_0000_0004);
            check("st_hold_count", bus.res_count, 96'd4);
        end
        bus.res_ready = 1'b1;
        cyc(1);
        bus.res_ready = 1'b0;
        check("st_done_valid", bus.res_valid, 96'd0);
        check("st_done_data",  bus.res_data,  96'd0);

        // ---------------- overflow on 64-bit accumulator ----------------
`ifdef WALLACE_MAC_SAT_EN
        exp_ovf_data = 96'h0_FFFF_FFFF_FFFF_FFFF;
`else
        exp_ovf_data = 96'h0_FFFF_FFFC_0000_0002;
`endif
        beat64(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        cyc(1);
        beat64(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        cyc(1);
        idle();
        cyc(2);
        check("ov_res_valid", bus64.res_valid, 96'd1);
        check("ov_res_ovf",   bus64.res_ovf,   96'd1);
        check("ov_res_data",  bus64.res_data,  exp_ovf_data);
        check("ov_res_count", bus64.res_count, 96'd2);
        bus64.res_ready = 1'b1;
        cyc(1);
        bus64.res_ready = 1'b0;
        check("ov_ovf_cleared", bus64.res_ovf,   96'd0);
        check("ov_in_ready",    bus64.in_ready,  96'd1);

        // ---------------- abort with a new first beat ----------------
        beat(32'd100, 32'd100, 1'b0);
        cyc(1);
        beat(32'd100, 32'd100, 1'b0);
        cyc(1);
        beat(32'd7, 32'd6, 1'b1);
        bus.acc_clr = 1'b1;
        cyc(1);
        idle();
        cyc(2);
        check("ab_res_valid", bus.res_valid, 96'd1);
        check("ab_res_data",  bus.res_data,  96'd42);
        check("ab_res_count", bus.res_count, 96'd1);
        bus.res_ready = 1'b1;
        cyc(1);
        bus.res_ready = 1'b0;
        check("ab_done_valid", bus.res_valid, 96'd0);

        // ---------------- async reset while flushing ----------------
        beat(32'd9, 32'd9, 1'b1);
        cyc(1);
        idle();
        check("ar_flush_ready", bus.in_ready, 96'd0);
        #1 rst_n = 1'b0;
        #1;
        check("ar_in_ready",  bus.in_ready,  96'd1);
        check("ar_res_valid", bus.res_valid, 96'd0);
        check("ar_mul_a",     bus.mul_a,     96'd0);
        check("ar_mul_b",     bus.mul_b,     96'd0);
        check("ar_res_count", bus.res_count, 96'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1);
        beat(32'd2, 32'd2, 1'b1);
        cyc(1);
        idle();
        cyc(2);
        check("ar_next_valid", bus.res_valid, 96'd1);
        check("ar_next_data",  bus.res_data,  96'd4);
        check("ar_next_count", bus.res_count, 96'd1);
        bus.res_ready = 1'b1;
        cyc(1);
        bus.res_ready = 1'b0;
        check("ar_next_done", bus.res_valid, 96'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
